// File: rtl/tft_panel_driver.sv
`default_nettype none
// ============================================================================
// Module   : tft_panel_driver
// Desc     : Video stream to parallel RGB TFT panel with frame lock check,
//            status counters and backlight PWM. Optional macro
//            TFT_TEST_PATTERN_EN shows colour bars while unlocked.
// Revision : 1.0  initial release
// ============================================================================
module tft_panel_driver #(
  parameter int H_ACTIVE    = 800,
  parameter int V_ACTIVE    = 480,
  parameter bit HS_ACT_HIGH = 1'b0,
  parameter bit VS_ACT_HIGH = 1'b0
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] vid_data,
  input  logic        vid_datavalid,
  input  logic        vid_h_sync,
  input  logic        vid_v_sync,
  input  logic        vid_underflow,
  input  logic [7:0]  bl_duty,
  input  logic        err_clr,
  output logic [7:0]  lcd_r,
  output logic [7:0]  lcd_g,
  output logic [7:0]  lcd_b,
  output logic        lcd_de,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_bl,
  output logic        locked,
  output logic        err_sticky,
  output logic [15:0] underflow_cnt
);

  localparam logic [15:0] H_LEN = 16'(H_ACTIVE);
  localparam logic [15:0] V_LEN = 16'(V_ACTIVE);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    LOCKED  = 2'd1,
    RESYNC  = 2'd2
  } state_e;

  // Reset asserts asynchronously but is released on a clock edge.
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) rst_sync_q <= 2'b00;
    else                rst_sync_q <= rst_sync_d;
  end

  assign rst_n = rst_sync_q[1];

  state_e      state_q, state_d;
  logic        vs_prev_q, vs_prev_d;
  logic        de_prev_q, de_prev_d;
  logic [15:0] pix_cnt_q, pix_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic        err_sticky_q, err_sticky_d;
  logic [15:0] uf_cnt_q, uf_cnt_d;
  logic [23:0] s1_rgb_q, s1_rgb_d;
  logic        s1_de_q, s1_de_d;
  logic        s1_hs_q, s1_hs_d;
  logic        s1_vs_q, s1_vs_d;
  logic [23:0] lcd_rgb_q, lcd_rgb_d;
  logic        lcd_de_q, lcd_de_d;
  logic        lcd_hs_q, lcd_hs_d;
  logic        lcd_vs_q, lcd_vs_d;
  logic [7:0]  bl_cnt_q, bl_cnt_d;
  logic [7:0]  duty_q, duty_d;
  logic        vs_rise, run_end, run_err;
  logic        unused_hi;

  assign unused_hi = ^vid_data[31:24];

`ifdef TFT_TEST_PATTERN_EN
  localparam logic [15:0] BAR_W = 16'((H_ACTIVE / 8 < 1) ? 1 : H_ACTIVE / 8);
  logic [15:0] pix_idx;
  logic [15:0] bar_num;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;

  // Bar order W,Y,C,G,M,R,B,K makes each colour bit a single inverted index bit.
  always_comb begin
    pix_idx = de_prev_q ? pix_cnt_q : 16'd0;
    bar_num = pix_idx / BAR_W;
    bar_idx = (bar_num > 16'd7) ? 3'd7 : bar_num[2:0];
    bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
  end
`endif

  always_comb begin
    vs_rise   = vid_v_sync & ~vs_prev_q;
    run_end   = de_prev_q & ~vid_datavalid;
    run_err   = run_end && (pix_cnt_q != H_LEN);
    vs_prev_d = vid_v_sync;
    de_prev_d = vid_datavalid;

    pix_cnt_d = pix_cnt_q;
    if (vid_datavalid) begin
      if (!de_prev_q)             pix_cnt_d = 16'd1;
      else if (pix_cnt_q != '1)   pix_cnt_d = pix_cnt_q + 16'd1;
    end

    state_d = state_q;
    case (state_q)
      WAIT_VS, RESYNC: if (vs_rise) state_d = LOCKED;
      LOCKED: begin
        // Underflow and a bad run win over a VS edge in the same cycle.
        if (vid_underflow || run_err || (vs_rise && (line_cnt_q != V_LEN)))
          state_d = RESYNC;
      end
      default: state_d = WAIT_VS;
    endcase

    line_cnt_d = line_cnt_q;
    if ((state_q != LOCKED) || vs_rise) line_cnt_d = 16'd0;
    else if (run_end && (line_cnt_q != '1)) line_cnt_d = line_cnt_q + 16'd1;

    err_sticky_d = err_sticky_q;
    if (err_clr) err_sticky_d = 1'b0;
    else if ((state_q == LOCKED) && (state_d == RESYNC)) err_sticky_d = 1'b1;

    uf_cnt_d = uf_cnt_q;
    if (err_clr) uf_cnt_d = 16'd0;
    else if (vid_underflow && (uf_cnt_q != '1)) uf_cnt_d = uf_cnt_q + 16'd1;

    // Gating uses the next state so the locking VS edge opens the frame.
    s1_de_d  = 1'b0;
    s1_rgb_d = 24'd0;
    if (state_d == LOCKED) begin
      s1_de_d  = vid_datavalid;
      s1_rgb_d = vid_data[23:0];
    end
`ifdef TFT_TEST_PATTERN_EN
    else begin
      s1_de_d = vid_datavalid;
      if (vid_datavalid) s1_rgb_d = bar_rgb;
    end
`endif
    s1_hs_d = vid_h_sync;
    s1_vs_d = vid_v_sync;

    lcd_rgb_d = s1_rgb_q;
    lcd_de_d  = s1_de_q;
    lcd_hs_d  = s1_hs_q ^ ~HS_ACT_HIGH;
    lcd_vs_d  = s1_vs_q ^ ~VS_ACT_HIGH;

    bl_cnt_d = bl_cnt_q + 8'd1;
    duty_d   = (bl_cnt_q == 8'hFF) ? bl_duty : duty_q;
  end

  always_ff @(posedge clk_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_VS;
      vs_prev_q    <= 1'b0;
      de_prev_q    <= 1'b0;
      pix_cnt_q    <= 16'd0;
      line_cnt_q   <= 16'd0;
      err_sticky_q <= 1'b0;
      uf_cnt_q     <= 16'd0;
      s1_rgb_q     <= 24'd0;
      s1_de_q      <= 1'b0;
      s1_hs_q      <= 1'b0;
      s1_vs_q      <= 1'b0;
      lcd_rgb_q    <= 24'd0;
      lcd_de_q     <= 1'b0;
      lcd_hs_q     <= ~HS_ACT_HIGH;
      lcd_vs_q     <= ~VS_ACT_HIGH;
      bl_cnt_q     <= 8'd0;
      duty_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      vs_prev_q    <= vs_prev_d;
      de_prev_q    <= de_prev_d;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      err_sticky_q <= err_sticky_d;
      uf_cnt_q     <= uf_cnt_d;
      s1_rgb_q     <= s1_rgb_d;
      s1_de_q      <= s1_de_d;
      s1_hs_q      <= s1_hs_d;
      s1_vs_q      <= s1_vs_d;
      lcd_rgb_q    <= lcd_rgb_d;
      lcd_de_q     <= lcd_de_d;
      lcd_hs_q     <= lcd_hs_d;
      lcd_vs_q     <= lcd_vs_d;
      bl_cnt_q     <= bl_cnt_d;
      duty_q       <= duty_d;
    end
  end

  assign lcd_r         = lcd_rgb_q[23:16];
  assign lcd_g         = lcd_rgb_q[15:8];
  assign lcd_b         = lcd_rgb_q[7:0];
  assign lcd_de        = lcd_de_q;
  assign lcd_hs        = lcd_hs_q;
  assign lcd_vs        = lcd_vs_q;
  assign lcd_bl        = (bl_cnt_q < duty_q);
  assign locked        = (state_q == LOCKED);
  assign err_sticky    = err_sticky_q;
  assign underflow_cnt = uf_cnt_q;

endmodule
`default_nettype wire
